// File: rtl/ddr_pkg.sv
// Shared types and default timing for the DDR4 command sequencer.
package ddr_pkg;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ACT = 3'd1,
    RD  = 3'd2,
    WR  = 3'd3,
    PRE = 3'd4,
    REF = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_WAIT
  } state_e;

  localparam int NUM_BG    = 4;
  localparam int NUM_BA    = 4;
  localparam int NUM_BANKS = NUM_BG * NUM_BA;

  localparam int ROW_W_DEF  = 14;
  localparam int COL_W_DEF  = 10;
  localparam int T_INIT_DEF = 16;
  localparam int T_RCD_DEF  = 4;
  localparam int T_RAS_DEF  = 10;
  localparam int T_RP_DEF   = 4;
  localparam int T_CCD_DEF  = 4;
  localparam int T_RFC_DEF  = 26;

  // A17..A0 as a vector; bits 16:14 double as RAS_n/CAS_n/WE_n, so deselect is 1s there.
  localparam logic [17:0] ADDR_DES = 18'h1_C000;

  // Counters are loaded on the edge that puts a command on the pins, so a
  // constraint of t cycles needs t-1 to reach zero by the deciding cycle.
  function automatic logic [7:0] tc_load(input int t);
    return 8'(t - 1);
  endfunction

endpackage

// File: rtl/ddr_bank_timer.sv
// Per-bank open flag and tRCD/tRAS/tRP down-counters.
module ddr_bank_timer
  import ddr_pkg::*;
#(
  parameter int T_RCD = T_RCD_DEF,
  parameter int T_RAS = T_RAS_DEF,
  parameter int T_RP  = T_RP_DEF
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic do_act,
  input  logic do_close,
  output logic bank_open,
  output logic can_act,
  output logic can_rdwr,
  output logic can_pre
);

  logic [7:0] rcd_cnt, ras_cnt, rp_cnt;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      bank_open <= 1'b0;
      rcd_cnt   <= '0;
      ras_cnt   <= '0;
      rp_cnt    <= '0;
    end else begin
      if (do_act) begin
        bank_open <= 1'b1;
        rcd_cnt   <= tc_load(T_RCD);
        ras_cnt   <= tc_load(T_RAS);
      end else begin
        if (do_close) bank_open <= 1'b0;
        if (rcd_cnt != 8'd0) rcd_cnt <= rcd_cnt - 8'd1;
        if (ras_cnt != 8'd0) ras_cnt <= ras_cnt - 8'd1;
      end
      if (do_close) rp_cnt <= tc_load(T_RP);
      else if (rp_cnt != 8'd0) rp_cnt <= rp_cnt - 8'd1;
    end
  end

  assign can_act  = !bank_open && (rp_cnt == 8'd0);
  assign can_rdwr = bank_open && (rcd_cnt == 8'd0);
  assign can_pre  = !bank_open || (ras_cnt == 8'd0);

endmodule

// File: rtl/ddr_cmd_sequencer.sv
// Single-request DDR4 command sequencer: holds one request, waits on timers, drives pins.
//  state  | meaning
//  S_INIT | CKE low, power-up count running
//  S_IDLE | holding register empty, ready for a request
//  S_WAIT | request held until its timers allow issue (or it is found illegal)
module ddr_cmd_sequencer
  import ddr_pkg::*;
#(
  parameter int ROW_W  = ROW_W_DEF,
  parameter int COL_W  = COL_W_DEF,
  parameter int T_INIT = T_INIT_DEF,
  parameter int T_RCD  = T_RCD_DEF,
  parameter int T_RAS  = T_RAS_DEF,
  parameter int T_RP   = T_RP_DEF,
  parameter int T_CCD  = T_CCD_DEF,
  parameter int T_RFC  = T_RFC_DEF
) (
  input  logic             CK_t,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_cmd,
  input  logic [1:0]       req_bg,
  input  logic [1:0]       req_ba,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  input  logic             req_ap,
  input  logic             req_bc,
  output logic             init_done,
  output logic             cmd_err,
  output logic             CKE,
  output logic             cs_n,
  output logic             act_n,
  output logic             RAS_n_A16,
  output logic             CAS_n_A15,
  output logic             WE_n_A14,
  output logic [1:0]       bg_addr,
  output logic [1:0]       ba_addr,
  output logic             A17,
  output logic             A13,
  output logic             A12_BC_n,
  output logic             A11,
  output logic             A10_AP,
  output logic [9:0]       A9_A0
);

  state_e state_q, state_d;
  logic [7:0] init_cnt, ccd_cnt, rfc_cnt;

  cmd_e             h_cmd;
  logic [1:0]       h_bg, h_ba;
  logic [ROW_W-1:0] h_row;
  logic [COL_W-1:0] h_col;
  logic             h_ap, h_bc;

  logic [NUM_BANKS-1:0] bank_open, can_act, can_rdwr, can_pre, do_act, do_close;
  logic [3:0]  sel;
  logic        go, err, load;
  logic        cs_d, act_d;
  logic [1:0]  bg_d, ba_d;
  logic [17:0] addr_d, addr_q;

  assign sel = {h_bg, h_ba};

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    ddr_bank_timer #(.T_RCD(T_RCD), .T_RAS(T_RAS), .T_RP(T_RP)) u_bank (
      .clk_sys  (CK_t),
      .rst      (reset),
      .do_act   (do_act[i]),
      .do_close (do_close[i]),
      .bank_open(bank_open[i]),
      .can_act  (can_act[i]),
      .can_rdwr (can_rdwr[i]),
      .can_pre  (can_pre[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    go        = 1'b0;
    err       = 1'b0;
    load      = 1'b0;
    do_act    = '0;
    do_close  = '0;
    cs_d      = 1'b1;
    act_d     = 1'b1;
    bg_d      = 2'd0;
    ba_d      = 2'd0;
    addr_d    = ADDR_DES;

    // Legality is judged only once the global timers would let the command out.
    if (state_q == S_WAIT && rfc_cnt == 8'd0) begin
      case (h_cmd)
        ACT:     if (bank_open[sel]) err = 1'b1; else go = can_act[sel];
        RD, WR:  if (ccd_cnt == 8'd0) begin
                   if (!bank_open[sel]) err = 1'b1; else go = can_rdwr[sel];
                 end
        PRE:     go = h_ap ? &can_pre : can_pre[sel];
        REF:     if (|bank_open) err = 1'b1; else go = 1'b1;
        default: go = 1'b1;
      endcase
    end

    if (go) begin
      cs_d = 1'b0;
      case (h_cmd)
        ACT: begin
          act_d       = 1'b0;
          bg_d        = h_bg;
          ba_d        = h_ba;
          addr_d      = 18'(h_row);
          do_act[sel] = 1'b1;
        end
        RD, WR: begin
          bg_d          = h_bg;
          ba_d          = h_ba;
          addr_d        = 18'(h_col);
          addr_d[16:14] = {1'b1, 1'b0, h_cmd == RD};
          addr_d[12]    = ~h_bc;
          addr_d[10]    = h_ap;
          do_close[sel] = h_ap;
        end
        PRE: begin
          addr_d        = '0;
          addr_d[16:14] = 3'b010;
          addr_d[10]    = h_ap;
          if (h_ap) begin
            do_close = '1;
          end else begin
            bg_d          = h_bg;
            ba_d          = h_ba;
            do_close[sel] = 1'b1;
          end
        end
        REF: begin
          addr_d        = '0;
          addr_d[16:14] = 3'b001;
        end
        default: cs_d = 1'b1;
      endcase
    end

    case (state_q)
      S_INIT: if (init_cnt == 8'd0) state_d = S_IDLE;
      S_IDLE: req_ready = 1'b1;
      S_WAIT: begin
        req_ready = go | err;
        if (go | err) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase

    // NOP is accepted but never held.
    if (req_valid && req_ready && (cmd_e'(req_cmd) inside {ACT, RD, WR, PRE, REF})) begin
      load    = 1'b1;
      state_d = S_WAIT;
    end
  end

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      state_q   <= S_INIT;
      init_cnt  <= tc_load(T_INIT);
      ccd_cnt   <= '0;
      rfc_cnt   <= '0;
      CKE       <= 1'b0;
      init_done <= 1'b0;
      cmd_err   <= 1'b0;
      cs_n      <= 1'b1;
      act_n     <= 1'b1;
      bg_addr   <= '0;
      ba_addr   <= '0;
      addr_q    <= ADDR_DES;
      h_cmd     <= NOP;
      h_bg      <= '0;
      h_ba      <= '0;
      h_row     <= '0;
      h_col     <= '0;
      h_ap      <= 1'b0;
      h_bc      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) begin
        if (init_cnt != 8'd0) begin
          init_cnt <= init_cnt - 8'd1;
        end else begin
          CKE       <= 1'b1;
          init_done <= 1'b1;
        end
      end
      if (go && (h_cmd == RD || h_cmd == WR)) ccd_cnt <= tc_load(T_CCD);
      else if (ccd_cnt != 8'd0) ccd_cnt <= ccd_cnt - 8'd1;
      if (go && h_cmd == REF) rfc_cnt <= tc_load(T_RFC);
      else if (rfc_cnt != 8'd0) rfc_cnt <= rfc_cnt - 8'd1;
      cmd_err <= err;
      cs_n    <= cs_d;
      act_n   <= act_d;
      bg_addr <= bg_d;
      ba_addr <= ba_d;
      addr_q  <= addr_d;
      if (load) begin
        h_cmd <= cmd_e'(req_cmd);
        h_bg  <= req_bg;
        h_ba  <= req_ba;
        h_row <= req_row;
        h_col <= req_col;
        h_ap  <= req_ap;
        h_bc  <= req_bc;
      end
    end
  end

  assign {A17, RAS_n_A16, CAS_n_A15, WE_n_A14, A13, A12_BC_n, A11, A10_AP} = addr_q[17:10];
  assign A9_A0 = addr_q[9:0];

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Scoreboard bench: absolute-time timing model predicts each pin event; monitor compares.
module tb_ddr_cmd_sequencer;
  import ddr_pkg::*;

  localparam int TI = 16, TRCD = 4, TRAS = 10, TRP = 4, TCCD = 4, TRFC = 26;
  localparam logic [24:0] DES = {1'b1, 1'b1, 2'd0, 2'd0, 18'h1_C000, 1'b0};

  logic CK_t = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [2:0] req_cmd = '0;
  logic [1:0] req_bg = '0, req_ba = '0;
  logic [13:0] req_row = '0;
  logic [9:0] req_col = '0;
  logic req_ap = 1'b0, req_bc = 1'b0;
  logic init_done, cmd_err, CKE, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
  logic [1:0] bg_addr, ba_addr;
  logic A17, A13, A12_BC_n, A11, A10_AP;
  logic [9:0] A9_A0;

  ddr_cmd_sequencer #(.ROW_W(14), .COL_W(10), .T_INIT(TI), .T_RCD(TRCD), .T_RAS(TRAS),
                      .T_RP(TRP), .T_CCD(TCCD), .T_RFC(TRFC)) dut (
    .CK_t(CK_t), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
    .req_col(req_col), .req_ap(req_ap), .req_bc(req_bc), .init_done(init_done),
    .cmd_err(cmd_err), .CKE(CKE), .cs_n(cs_n), .act_n(act_n), .RAS_n_A16(RAS_n_A16),
    .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14), .bg_addr(bg_addr), .ba_addr(ba_addr),
    .A17(A17), .A13(A13), .A12_BC_n(A12_BC_n), .A11(A11), .A10_AP(A10_AP), .A9_A0(A9_A0)
  );

  always #5 CK_t = ~CK_t;

  longint cyc = 0;
  always @(posedge CK_t) cyc <= cyc + 1;

  typedef struct {
    longint      cyc;
    logic [24:0] pins;
  } exp_t;

  exp_t   exp_q[$];
  longint obs_q[$];
  int     n_cmp = 0, n_bad = 0;

  bit     open_b[16];
  longint act_t[16], close_t[16];
  longint rdwr_t, ref_t, busy_f, last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint mx(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      open_b[i]  = 1'b0;
      act_t[i]   = -1000;
      close_t[i] = -1000;
    end
    rdwr_t = -1000;
    ref_t  = -1000;
    busy_f = 0;
    exp_q.delete();
  endtask

  always @(posedge CK_t) begin : monitor
    logic [24:0] a;
    exp_t e;
    #1;
    if (!reset) begin
      a = {cs_n, act_n, bg_addr, ba_addr, A17, RAS_n_A16, CAS_n_A15, WE_n_A14,
           A13, A12_BC_n, A11, A10_AP, A9_A0, cmd_err};
      if (a !== DES) begin
        obs_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_pin_event", a, DES);
        end else begin
          e = exp_q.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("event_pins", a, e.pins);
        end
      end else begin
        n_cmp++;
      end
    end
  end

  // Called and returns right after a falling edge.
  task automatic send(input cmd_e c, input int bg, input int ba, input logic [13:0] row,
                      input logic [9:0] col, input bit ap, input bit bc);
    longint ex, acc, g, t;
    int b, k;
    bit err_e;
    logic [17:0] ad;
    logic [1:0] obg, oba;
    req_valid = 1'b1; req_cmd = c; req_bg = bg[1:0]; req_ba = ba[1:0];
    req_row = row; req_col = col; req_ap = ap; req_bc = bc;
    ex = mx(cyc + 1, busy_f);
    k = 0;
    while (!req_ready && k < 600) begin
      @(negedge CK_t);
      k++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 1'b0, 1'b1);
      req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    last_acc = acc;
    chk("accept_cycle", acc, ex);
    b = bg * 4 + ba;
    g = mx(acc + 1, ref_t + TRFC);
    t = g;
    err_e = 1'b0;
    case (c)
      ACT: if (open_b[b]) err_e = 1'b1; else t = mx(g, close_t[b] + TRP);
      RD, WR: begin
        g = mx(g, rdwr_t + TCCD);
        t = g;
        if (!open_b[b]) err_e = 1'b1; else t = mx(g, act_t[b] + TRCD);
      end
      PRE: begin
        if (ap) begin
          for (int i = 0; i < 16; i++) if (open_b[i]) t = mx(t, act_t[i] + TRAS);
        end else if (open_b[b]) begin
          t = mx(g, act_t[b] + TRAS);
        end
      end
      REF: for (int i = 0; i < 16; i++) if (open_b[i]) err_e = 1'b1;
      default: ;
    endcase
    if (c == NOP) begin
      busy_f = acc;
    end else begin
      busy_f = t;
      if (err_e) begin
        exp_q.push_back('{t, {DES[24:1], 1'b1}});
      end else begin
        obg = bg[1:0]; oba = ba[1:0];
        case (c)
          ACT: begin
            ad = {4'b0000, row};
            open_b[b] = 1'b1; act_t[b] = t;
            exp_q.push_back('{t, {1'b0, 1'b0, obg, oba, ad, 1'b0}});
          end
          RD, WR: begin
            ad = {1'b0, 1'b1, 1'b0, (c == RD), 1'b0, ~bc, 1'b0, ap, col};
            rdwr_t = t;
            if (ap) begin open_b[b] = 1'b0; close_t[b] = t; end
            exp_q.push_back('{t, {1'b0, 1'b1, obg, oba, ad, 1'b0}});
          end
          PRE: begin
            ad = {1'b0, 3'b010, 3'b000, ap, 10'd0};
            if (ap) begin
              obg = 2'd0; oba = 2'd0;
              for (int i = 0; i < 16; i++) begin open_b[i] = 1'b0; close_t[i] = t; end
            end else begin
              open_b[b] = 1'b0; close_t[b] = t;
            end
            exp_q.push_back('{t, {1'b0, 1'b1, obg, oba, ad, 1'b0}});
          end
          default: begin
            ad = {1'b0, 3'b001, 14'd0};
            ref_t = t;
            exp_q.push_back('{t, {1'b0, 1'b1, 2'd0, 2'd0, ad, 1'b0}});
          end
        endcase
      end
    end
    @(negedge CK_t);
    req_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge CK_t);
      k++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic wait_events(input int n);
    int k;
    k = 0;
    while (obs_q.size() < n && k < 400) begin
      @(negedge CK_t);
      k++;
    end
    chk("event_seen", obs_q.size() >= n, 1'b1);
  endtask

  // Starts just after reset is released on a falling edge.
  task automatic init_check();
    int k;
    k = 0;
    while (k < 40) begin
      @(posedge CK_t);
      #1;
      k++;
      if (CKE === 1'b1) break;
      chk("init_done_low", init_done, 1'b0);
    end
    chk("cke_delay", k, TI);
    chk("init_done", init_done, 1'b1);
    chk("ready_after_init", req_ready, 1'b1);
    @(negedge CK_t);
  endtask

  task automatic check_reset_outputs();
    chk("rst_cke", CKE, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_cmd_err", cmd_err, 1'b0);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_addr", {A17, A13, A12_BC_n, A11, A10_AP, A9_A0}, 15'd0);
  endtask

  initial begin
    int n0, r;
    cmd_e c;
    model_reset();
    repeat (3) @(negedge CK_t);
    check_reset_outputs();
    reset = 1'b0;
    init_check();

    // RD to a closed bank is dropped with an error pulse
    send(RD, 0, 0, 14'd0, 10'h155, 1'b0, 1'b0);
    wait_quiet();
    chk("ready_after_err", req_ready, 1'b1);

    // ACT then RD: tRCD gap
    n0 = obs_q.size();
    send(ACT, 1, 2, 14'h1ABC, 10'd0, 1'b0, 1'b0);
    send(RD, 1, 2, 14'd0, 10'h3F0, 1'b0, 1'b0);
    wait_quiet();
    chk("rcd_gap", obs_q[n0 + 1] - obs_q[n0], TRCD);

    // WR, WR: tCCD gap, second accepted only when first issues
    n0 = obs_q.size();
    send(WR, 1, 2, 14'd0, 10'h011, 1'b0, 1'b1);
    send(WR, 1, 2, 14'd0, 10'h022, 1'b0, 1'b0);
    wait_quiet();
    chk("ccd_gap", obs_q[n0 + 1] - obs_q[n0], TCCD);
    chk("second_wr_accept", last_acc, obs_q[n0]);

    // ACT, PRE requested 3 cycles later, ACT again
    n0 = obs_q.size();
    send(ACT, 2, 3, 14'h0777, 10'd0, 1'b0, 1'b0);
    wait_events(n0 + 1);
    repeat (2) @(negedge CK_t);
    send(PRE, 2, 3, 14'd0, 10'd0, 1'b0, 1'b0);
    send(ACT, 2, 3, 14'h2345, 10'd0, 1'b0, 1'b0);
    wait_quiet();
    chk("ras_gap", obs_q[n0 + 1] - obs_q[n0], TRAS);
    chk("rp_gap", obs_q[n0 + 2] - obs_q[n0 + 1], TRP);

    // REF with banks open errors; PRE-all, REF, then ACT after tRFC
    n0 = obs_q.size();
    send(REF, 0, 0, 14'd0, 10'd0, 1'b0, 1'b0);
    send(PRE, 0, 0, 14'd0, 10'd0, 1'b1, 1'b0);
    send(REF, 0, 0, 14'd0, 10'd0, 1'b0, 1'b0);
    send(ACT, 0, 1, 14'h0F0F, 10'd0, 1'b0, 1'b0);
    wait_quiet();
    chk("rfc_gap", obs_q[n0 + 3] - obs_q[n0 + 2], TRFC);

    // Randomized traffic over a handful of banks
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge CK_t);
      r = $urandom_range(0, 31);
      if (r < 8) c = ACT;
      else if (r < 14) c = RD;
      else if (r < 20) c = WR;
      else if (r < 27) c = PRE;
      else if (r < 29) c = REF;
      else if (r < 30) c = NOP;
      else c = RD;
      send(c, $urandom_range(0, 3), $urandom_range(0, 1), 14'($urandom), 10'($urandom),
           ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
    end
    wait_quiet();

    // Reset while a PRE is held: outputs drop at once, bank state cleared
    n0 = obs_q.size();
    send(ACT, 3, 1, 14'h1111, 10'd0, 1'b0, 1'b0);
    wait_events(n0 + 1);
    send(PRE, 3, 1, 14'd0, 10'd0, 1'b0, 1'b0);
    repeat (2) @(negedge CK_t);
    @(posedge CK_t);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (3) @(negedge CK_t);
    reset = 1'b0;
    init_check();
    send(ACT, 3, 1, 14'h2222, 10'd0, 1'b0, 1'b0);
    wait_quiet();

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish by time %0t", $time);
    $fatal(1);
  end

endmodule
